matrix_result_streamer: RTL and testbench

MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

---
 rtl/matrix_pkg.sv | 14 +
 rtl/matrix_result_streamer_if.sv | 26 ++
 rtl/elem_saturate.sv | 12 +
 rtl/matrix_result_streamer.sv | 88 ++++++++
 tb/tb_matrix_result_streamer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// Shared widths, saturation limit and state encoding for the matrix result streamer.
package matrix_pkg;
    localparam int ELEM_W = 32;
    localparam int N_ELEM = 16;
    localparam int MAT_W  = ELEM_W * N_ELEM;
    localparam int IDX_W  = $clog2(N_ELEM);

    localparam logic [15:0] SAT_LIMIT = 16'hFFFF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;
endpackage

// File: rtl/matrix_result_streamer_if.sv
// Load side and element stream of the matrix result streamer; master is the streamer itself.
interface matrix_result_streamer_if;
    import matrix_pkg::*;

    logic               load;
    logic [MAT_W-1:0]   matrix_in;
    logic               narrow;
    logic               load_ready;
    logic [ELEM_W-1:0]  out_data;
    logic [1:0]         out_row;
    logic [1:0]         out_col;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic [7:0]         frames_done;

    modport master (
        input  load, matrix_in, narrow, out_ready,
        output load_ready, out_data, out_row, out_col, out_valid, out_last, frames_done
    );

    modport slave (
        output load, matrix_in, narrow, out_ready,
        input  load_ready, out_data, out_row, out_col, out_valid, out_last, frames_done
    );
endinterface

// File: rtl/elem_saturate.sv
// Clamps one element to the 16-bit limit when narrow is set; purely combinational.
module elem_saturate
    import matrix_pkg::*;
(
    input  logic [ELEM_W-1:0] elem_in,
    input  logic              narrow,
    output logic [ELEM_W-1:0] elem_out
);
    localparam logic [ELEM_W-1:0] LIMIT = ELEM_W'(SAT_LIMIT);

    assign elem_out = (narrow && (elem_in > LIMIT)) ? LIMIT : elem_in;
endmodule

// File: rtl/matrix_result_streamer.sv
// Captures a 4x4 product matrix and streams it element by element, row-major.
// One cycle load-to-valid; load is re-accepted on the final transfer so frames run back to back.
module matrix_result_streamer #(
    parameter int ELEM_W = matrix_pkg::ELEM_W,
    parameter int N_ELEM = matrix_pkg::N_ELEM
) (
    input  logic                       clk,
    input  logic                       reset,
    matrix_result_streamer_if.master   bus
);
    import matrix_pkg::*;

    localparam int              IW   = $clog2(N_ELEM);
    localparam logic [IW-1:0]   LAST = IW'(N_ELEM - 1);

    state_e                     state_q, state_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [N_ELEM*ELEM_W-1:0]   mat_q, mat_d;
    logic                       narrow_q, narrow_d;
    logic [7:0]                 frames_q, frames_d;

    logic                       streaming;
    logic                       at_last;
    logic                       xfer;
    logic                       accept;
    logic [ELEM_W-1:0]          elem_sel;

    always_comb begin
        streaming      = (state_q == ST_STREAM);
        at_last        = streaming && (idx_q == LAST);
        xfer           = streaming && bus.out_ready;
        bus.load_ready = !streaming || (at_last && bus.out_ready);
        accept         = bus.load && bus.load_ready;

        state_d  = state_q;
        idx_d    = idx_q;
        mat_d    = mat_q;
        narrow_d = narrow_q;
        frames_d = frames_q;

        if (xfer) begin
            idx_d = idx_q + 1'b1;
            if (at_last) begin
                frames_d = frames_q + 8'd1;
                state_d  = ST_IDLE;
            end
        end

        // A load accepted on the final transfer overrides the return to idle.
        if (accept) begin
            mat_d    = bus.matrix_in;
            narrow_d = bus.narrow;
            idx_d    = '0;
            state_d  = ST_STREAM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            mat_q    <= '0;
            narrow_q <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mat_q    <= mat_d;
            narrow_q <= narrow_d;
            frames_q <= frames_d;
        end
    end

    // Elements come only from the captured copy, so upstream may change matrix_in freely.
    assign elem_sel = mat_q[int'(idx_q) * ELEM_W +: ELEM_W];

    elem_saturate u_sat (
        .elem_in  (elem_sel),
        .narrow   (narrow_q),
        .elem_out (bus.out_data)
    );

    assign bus.out_valid   = streaming;
    assign bus.out_last    = at_last;
    assign bus.out_row     = idx_q[3:2];
    assign bus.out_col     = idx_q[1:0];
    assign bus.frames_done = frames_q;
endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench: stimulus pushes expected elements into a scoreboard, a negedge monitor checks them.
module tb_matrix_result_streamer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    matrix_result_streamer_if bus();

    matrix_result_streamer #(.ELEM_W(32), .N_ELEM(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [511:0] mk(input logic [31:0] base, input logic [31:0] step);
        logic [511:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) m[32*i +: 32] = base + step * 32'(i);
        return m;
    endfunction

    task automatic push_exp(input logic [511:0] m, input logic nar);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.data = m[32*i +: 32];
            if (nar && e.data > 32'h0000FFFF) e.data = 32'h0000FFFF;
            e.row  = 2'(i >> 2);
            e.col  = 2'(i & 3);
            e.last = (i == 15);
            sb.push_back(e);
        end
    endtask

    // Monitor: checks transfers against the scoreboard and output stability across stalls.
    exp_t mon_e;
    exp_t prev;
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
                chk("stall_data", bus.out_data, prev.data);
                chk("stall_pos", {27'b0, bus.out_row, bus.out_col, bus.out_last},
                    {27'b0, prev.row, prev.col, prev.last});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_xfer: got 0x%08h, expected no transfer", bus.out_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk("xfer_data", bus.out_data, mon_e.data);
                    chk("xfer_pos", {27'b0, bus.out_row, bus.out_col, bus.out_last},
                        {27'b0, mon_e.row, mon_e.col, mon_e.last});
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev       = {bus.out_data, bus.out_row, bus.out_col, bus.out_last};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mat(input logic [511:0] m, input logic nar);
        bus.matrix_in = m;
        bus.narrow    = nar;
        bus.load      = 1'b1;
        push_exp(m, nar);
        tick();
        bus.load      = 1'b0;
        bus.narrow    = 1'b0;
        bus.matrix_in = '1;
        chk("valid_after_load", {31'b0, bus.out_valid}, 32'd1);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 200 && sb.size() != 0; k++) tick();
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got %0d pending elements, expected 0", name, sb.size());
        end
        chk({name, "_idle"}, {31'b0, bus.out_valid}, 32'd0);
    endtask

    logic [511:0] mat_a, mat_b, mat_c;
    logic [3:0]   pat;

    initial begin
        mat_a = mk(32'h0000_0000, 32'h0001_0001);
        mat_b = mk(32'hA500_0000, 32'h0000_0101);
        mat_c = mk(32'hC000_0000, 32'h0000_0001);
        pat   = 4'b1001;

        bus.load = 1'b0;
        bus.narrow = 1'b0;
        bus.matrix_in = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) tick();
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_last", {31'b0, bus.out_last}, 32'd0);
        chk("rst_data", bus.out_data, 32'd0);
        chk("rst_pos", {28'b0, bus.out_row, bus.out_col}, 32'd0);
        chk("rst_frames", {24'b0, bus.frames_done}, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_load_ready", {31'b0, bus.load_ready}, 32'd1);

        // Plain stream, exact 16-cycle drain
        load_mat(mat_a, 1'b0);
        repeat (15) tick();
        chk("t1_last_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("t1_last_flag", {31'b0, bus.out_last}, 32'd1);
        tick();
        chk("t1_drained", {31'b0, bus.out_valid}, 32'd0);
        chk("t1_frames", {24'b0, bus.frames_done}, 32'd1);

        // Narrow: element 0 stays 0, the rest clamp to 0xFFFF
        load_mat(mat_a, 1'b1);
        drain("t2");
        chk("t2_frames", {24'b0, bus.frames_done}, 32'd2);

        // Backpressure pattern 1,0,0,1
        load_mat(mat_b, 1'b0);
        for (int c = 0; c < 200 && sb.size() != 0; c++) begin
            bus.out_ready = pat[c % 4];
            tick();
        end
        bus.out_ready = 1'b1;
        drain("t3");
        chk("t3_frames", {24'b0, bus.frames_done}, 32'd3);

        // Back-to-back load on the final transfer
        load_mat(mat_a, 1'b0);
        repeat (15) tick();
        bus.matrix_in = mat_c;
        bus.load = 1'b1;
        push_exp(mat_c, 1'b0);
        chk("t4_load_ready_last", {31'b0, bus.load_ready}, 32'd1);
        tick();
        bus.load = 1'b0;
        bus.matrix_in = '1;
        chk("t4_no_bubble", {31'b0, bus.out_valid}, 32'd1);
        chk("t4_first_data", bus.out_data, 32'hC000_0000);
        chk("t4_first_pos", {28'b0, bus.out_row, bus.out_col}, 32'd0);
        drain("t4");
        chk("t4_frames", {24'b0, bus.frames_done}, 32'd5);

        // Load pulse mid-stream is ignored
        load_mat(mat_a, 1'b0);
        repeat (5) tick();
        chk("t6_load_ready_busy", {31'b0, bus.load_ready}, 32'd0);
        bus.matrix_in = mat_c;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        drain("t6");
        chk("t6_frames", {24'b0, bus.frames_done}, 32'd6);

        // Reset after 7 transfers abandons the frame
        load_mat(mat_a, 1'b0);
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        chk("t5_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("t5_frames", {24'b0, bus.frames_done}, 32'd0);
        chk("t5_data", bus.out_data, 32'd0);
        chk("t5_load_ready", {31'b0, bus.load_ready}, 32'd1);
        load_mat(mat_c, 1'b1);
        chk("t5_restart_pos", {28'b0, bus.out_row, bus.out_col}, 32'd0);
        drain("t5");
        chk("t5_frames_after", {24'b0, bus.frames_done}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
